// File: rtl/gecko_pkg.sv
// Shared gecko types and helpers for the writeback stage: result payloads,
// load formatting and forwarding-bus construction.
package gecko_pkg;

    typedef logic       gecko_jump_flag_t;
    typedef logic [4:0] gecko_reg_addr_t;
    typedef logic [4:0] gecko_retired_count_t;

    typedef enum logic [2:0] {
        LS_B  = 3'd0,
        LS_H  = 3'd1,
        LS_W  = 3'd2,
        LS_BU = 3'd4,
        LS_HU = 3'd5
    } gecko_load_store_op_t;

    typedef struct packed {
        gecko_reg_addr_t  addr;
        logic [31:0]      value;
        logic             speculative;
        gecko_jump_flag_t jump_flag;
    } gecko_operation_t;

    typedef struct packed {
        gecko_load_store_op_t op;
        logic [1:0]           offset;
        gecko_reg_addr_t      addr;
    } gecko_mem_operation_t;

    typedef struct packed {
        logic            valid;
        gecko_reg_addr_t addr;
        logic [31:0]     value;
    } gecko_forwarded_t;

    typedef enum logic [1:0] {
        GECKO_WB_EXEC,
        GECKO_WB_SYS,
        GECKO_WB_LOAD
    } gecko_wb_source_t;

    // Byte lane selected by offset is shifted down before extension; unknown ops read a full word.
    function automatic gecko_operation_t gecko_get_load_operation(
        input gecko_mem_operation_t meta,
        input logic [31:0]          data
    );
        gecko_operation_t result;
        logic [31:0]      shifted;
        shifted            = data >> {meta.offset, 3'b000};
        result             = '0;
        result.addr        = meta.addr;
        result.speculative = 1'b0;
        case (meta.op)
            LS_B:    result.value = {{24{shifted[7]}}, shifted[7:0]};
            LS_H:    result.value = {{16{shifted[15]}}, shifted[15:0]};
            LS_BU:   result.value = {24'h0, shifted[7:0]};
            LS_HU:   result.value = {16'h0, shifted[15:0]};
            default: result.value = data;
        endcase
        return result;
    endfunction

    function automatic gecko_forwarded_t gecko_construct_forward(
        input logic             valid,
        input gecko_operation_t op
    );
        gecko_forwarded_t fwd;
        fwd.valid = valid;
        fwd.addr  = op.addr;
        fwd.value = op.value;
        return fwd;
    endfunction

endpackage

// File: rtl/gecko_wb_grant.sv
// Combinational three-source grant for the writeback port: load first, then
// exec/sys by round-robin pointer or fixed system-over-execute priority.
module gecko_wb_grant
    import gecko_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic             exec_valid,
    input  logic             sys_valid,
    input  logic             load_valid,
    input  gecko_wb_source_t rr_pointer,
    output logic [2:0]       grant
);

    always_comb begin
        grant = '0;
        if (load_valid) begin
            grant[GECKO_WB_LOAD] = 1'b1;
        end else if (ROUND_ROBIN && rr_pointer == GECKO_WB_EXEC) begin
            if (exec_valid)     grant[GECKO_WB_EXEC] = 1'b1;
            else if (sys_valid) grant[GECKO_WB_SYS]  = 1'b1;
        end else begin
            if (sys_valid)       grant[GECKO_WB_SYS]  = 1'b1;
            else if (exec_valid) grant[GECKO_WB_EXEC] = 1'b1;
        end
    end

endmodule

// File: rtl/gecko_writeback_arbiter.sv
// Register-file write port arbiter: grants one of load/system/execute per cycle,
// drops mis-speculated and x0 results, and registers the winning write.
module gecko_writeback_arbiter
    import gecko_pkg::*;
#(
    parameter bit ROUND_ROBIN     = 1'b1,
    parameter bit RETIRE_SATURATE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 exec_valid,
    output logic                 exec_ready,
    input  gecko_operation_t     exec_op,
    input  logic                 sys_valid,
    output logic                 sys_ready,
    input  gecko_operation_t     sys_op,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  gecko_mem_operation_t load_meta,
    input  logic [31:0]          load_data,
    input  gecko_jump_flag_t     current_jump_flag,
    output logic                 wb_valid,
    output gecko_operation_t     wb_op,
    output gecko_forwarded_t     forward,
    output gecko_retired_count_t retired_count
);

    gecko_wb_source_t rr_pointer, rr_next;
    logic [2:0]       grant;
    gecko_operation_t load_op, cand_op;
    logic             cand_write;

    gecko_wb_grant #(.ROUND_ROBIN(ROUND_ROBIN)) u_grant (
        .exec_valid (exec_valid),
        .sys_valid  (sys_valid),
        .load_valid (load_valid),
        .rr_pointer (rr_pointer),
        .grant      (grant)
    );

    assign load_op    = gecko_get_load_operation(load_meta, load_data);
    assign exec_ready = grant[GECKO_WB_EXEC] & ~rst;
    assign sys_ready  = grant[GECKO_WB_SYS] & ~rst;
    assign load_ready = ~rst;

    always_comb begin
        rr_next    = rr_pointer;
        cand_op    = '0;
        cand_write = 1'b0;
        if (grant[GECKO_WB_LOAD]) begin
            cand_op    = load_op;
            cand_write = (load_op.addr != '0);
        end else if (grant[GECKO_WB_SYS]) begin
            cand_op    = sys_op;
            cand_write = (sys_op.addr != '0) &&
                         !(sys_op.speculative && sys_op.jump_flag != current_jump_flag);
            if (rr_pointer == GECKO_WB_SYS) rr_next = GECKO_WB_EXEC;
        end else if (grant[GECKO_WB_EXEC]) begin
            cand_op    = exec_op;
            cand_write = (exec_op.addr != '0) &&
                         !(exec_op.speculative && exec_op.jump_flag != current_jump_flag);
            if (rr_pointer == GECKO_WB_EXEC) rr_next = GECKO_WB_SYS;
        end
        cand_op.speculative = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_pointer <= GECKO_WB_EXEC;
        else     rr_pointer <= rr_next;
    end

    // Count is bumped on the same edge that raises wb_valid so it tracks committed writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid      <= 1'b0;
            wb_op         <= '0;
            retired_count <= '0;
        end else begin
            wb_valid <= cand_write;
            if (cand_write) begin
                wb_op <= cand_op;
                if (!(RETIRE_SATURATE && retired_count == '1))
                    retired_count <= retired_count + 5'd1;
            end
        end
    end

    assign forward = gecko_construct_forward(wb_valid, wb_op);

endmodule

// File: tb/tb_gecko_writeback_arbiter.sv
// Directed bench for gecko_writeback_arbiter: a round-robin/saturating instance
// and a fixed-priority/wrapping instance share one stimulus stream.
module tb_gecko_writeback_arbiter;
    import gecko_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 exec_valid = 1'b0, sys_valid = 1'b0, load_valid = 1'b0;
    gecko_operation_t     exec_op = '0, sys_op = '0;
    gecko_mem_operation_t load_meta = '0;
    logic [31:0]          load_data = '0;
    gecko_jump_flag_t     current_jump_flag = 1'b0;

    logic                 exec_ready, sys_ready, load_ready, wb_valid;
    gecko_operation_t     wb_op;
    gecko_forwarded_t     forward;
    gecko_retired_count_t retired_count;

    logic                 fp_exec_ready, fp_sys_ready, fp_load_ready, fp_wb_valid;
    gecko_operation_t     fp_wb_op;
    gecko_forwarded_t     fp_forward;
    gecko_retired_count_t fp_retired_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gecko_writeback_arbiter #(.ROUND_ROBIN(1'b1), .RETIRE_SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_op(exec_op),
        .sys_valid(sys_valid), .sys_ready(sys_ready), .sys_op(sys_op),
        .load_valid(load_valid), .load_ready(load_ready), .load_meta(load_meta), .load_data(load_data),
        .current_jump_flag(current_jump_flag),
        .wb_valid(wb_valid), .wb_op(wb_op), .forward(forward), .retired_count(retired_count)
    );

    gecko_writeback_arbiter #(.ROUND_ROBIN(1'b0), .RETIRE_SATURATE(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .exec_valid(exec_valid), .exec_ready(fp_exec_ready), .exec_op(exec_op),
        .sys_valid(sys_valid), .sys_ready(fp_sys_ready), .sys_op(sys_op),
        .load_valid(load_valid), .load_ready(fp_load_ready), .load_meta(load_meta), .load_data(load_data),
        .current_jump_flag(current_jump_flag),
        .wb_valid(fp_wb_valid), .wb_op(fp_wb_op), .forward(fp_forward), .retired_count(fp_retired_count)
    );

    function automatic gecko_operation_t mk_op(input logic [4:0] a, input logic [31:0] v,
                                               input logic s, input logic j);
        gecko_operation_t o;
        o.addr = a; o.value = v; o.speculative = s; o.jump_flag = j;
        return o;
    endfunction

    function automatic gecko_mem_operation_t mk_meta(input logic [2:0] op, input logic [1:0] off,
                                                     input logic [4:0] a);
        gecko_mem_operation_t m;
        m.op = gecko_load_store_op_t'(op); m.offset = off; m.addr = a;
        return m;
    endfunction

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
        n_cmp++; if (wb_op !== '0) begin n_err++; $display("FAIL reset_wb_op: got %h want 0", wb_op); end
        n_cmp++; if (forward.valid !== 1'b0) begin n_err++; $display("FAIL reset_fwd_valid: got %b want 0", forward.valid); end
        n_cmp++; if (retired_count !== 5'd0) begin n_err++; $display("FAIL reset_retired: got %0d want 0", retired_count); end
        exec_valid = 1'b1; sys_valid = 1'b1; load_valid = 1'b1; #1;
        n_cmp++; if ({exec_ready, sys_ready, load_ready} !== 3'b000) begin n_err++; $display("FAIL reset_readies: got %b want 000", {exec_ready, sys_ready, load_ready}); end
        exec_valid = 1'b0; sys_valid = 1'b0; load_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_single_exec();
        @(negedge clk);
        exec_op = mk_op(5'd5, 32'hDEADBEEF, 1'b0, 1'b0); exec_valid = 1'b1; #1;
        n_cmp++; if (exec_ready !== 1'b1) begin n_err++; $display("FAIL single_exec_ready: got %b want 1", exec_ready); end
        n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL load_ready_idle: got %b want 1", load_ready); end
        @(posedge clk); #1; exec_valid = 1'b0;
        n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL single_wb_valid: got %b want 1", wb_valid); end
        n_cmp++; if (wb_op.addr !== 5'd5 || wb_op.value !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_wb_op: got %0d/%h want 5/deadbeef", wb_op.addr, wb_op.value); end
        n_cmp++; if (forward !== {1'b1, 5'd5, 32'hDEADBEEF}) begin n_err++; $display("FAIL single_forward: got %h want 1/5/deadbeef", forward); end
        n_cmp++; if (retired_count !== 5'd1) begin n_err++; $display("FAIL single_retired: got %0d want 1", retired_count); end
        @(posedge clk); #1;
        n_cmp++; if (wb_valid !== 1'b0 || wb_op.value !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_idle_hold: got %b/%h want 0/deadbeef", wb_valid, wb_op.value); end
    endtask

    task automatic test_load_format();
        logic [2:0]  ops   [3] = '{3'd0, 3'd5, 3'd7};
        logic [1:0]  offs  [3] = '{2'd2, 2'd2, 2'd0};
        logic [31:0] datas [3] = '{32'h0080_0000, 32'h8001_0000, 32'h1234_5678};
        logic [31:0] exps  [3] = '{32'hFFFF_FF80, 32'h0000_8001, 32'h1234_5678};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            load_meta = mk_meta(ops[i], offs[i], 5'd7); load_data = datas[i]; load_valid = 1'b1;
            @(posedge clk); #1; load_valid = 1'b0;
            n_cmp++; if (wb_valid !== 1'b1 || wb_op.value !== exps[i] || wb_op.addr !== 5'd7) begin
                n_err++; $display("FAIL load_format_%0d: got %b/%0d/%h want 1/7/%h", i, wb_valid, wb_op.addr, wb_op.value, exps[i]);
            end
        end
        n_cmp++; if (retired_count !== 5'd4) begin n_err++; $display("FAIL load_retired: got %0d want 4", retired_count); end
    endtask

    task automatic test_arbitration();
        pulse_reset();
        @(negedge clk);
        exec_op = mk_op(5'd1, 32'h11, 1'b0, 1'b0); sys_op = mk_op(5'd2, 32'h22, 1'b0, 1'b0);
        exec_valid = 1'b1; sys_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if ({exec_ready, sys_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_ready_%0d: got %b want %b", i, {exec_ready, sys_ready}, (i % 2 == 0) ? 2'b10 : 2'b01); end
            n_cmp++; if ({fp_exec_ready, fp_sys_ready} !== 2'b01) begin n_err++; $display("FAIL fp_ready_%0d: got %b want 01", i, {fp_exec_ready, fp_sys_ready}); end
            @(posedge clk); #1;
            n_cmp++; if (wb_op.addr !== ((i % 2 == 0) ? 5'd1 : 5'd2)) begin n_err++; $display("FAIL rr_grant_%0d: got %0d want %0d", i, wb_op.addr, (i % 2 == 0) ? 1 : 2); end
            n_cmp++; if (fp_wb_op.addr !== 5'd2) begin n_err++; $display("FAIL fp_grant_%0d: got %0d want 2", i, fp_wb_op.addr); end
            @(negedge clk);
        end
    endtask

    task automatic test_load_priority();
        load_meta = mk_meta(3'd2, 2'd0, 5'd9); load_data = 32'hCAFE_F00D; load_valid = 1'b1; #1;
        n_cmp++; if ({load_ready, exec_ready, sys_ready} !== 3'b100) begin n_err++; $display("FAIL prio_ready: got %b want 100", {load_ready, exec_ready, sys_ready}); end
        @(posedge clk); #1;
        n_cmp++; if (wb_op.addr !== 5'd9 || wb_op.value !== 32'hCAFE_F00D) begin n_err++; $display("FAIL prio_load_wb: got %0d/%h want 9/cafef00d", wb_op.addr, wb_op.value); end
        n_cmp++; if (fp_wb_op.addr !== 5'd9) begin n_err++; $display("FAIL prio_fp_load_wb: got %0d want 9", fp_wb_op.addr); end
        @(negedge clk); load_valid = 1'b0; #1;
        n_cmp++; if ({exec_ready, sys_ready} !== 2'b10) begin n_err++; $display("FAIL prio_rr_kept: got %b want 10", {exec_ready, sys_ready}); end
        n_cmp++; if ({fp_exec_ready, fp_sys_ready} !== 2'b01) begin n_err++; $display("FAIL prio_fp_after: got %b want 01", {fp_exec_ready, fp_sys_ready}); end
        @(posedge clk); #1; exec_valid = 1'b0; sys_valid = 1'b0;
        n_cmp++; if (wb_op.addr !== 5'd1 || retired_count !== 5'd6) begin n_err++; $display("FAIL prio_exec_wb: got %0d/%0d want 1/6", wb_op.addr, retired_count); end
        n_cmp++; if (fp_wb_op.addr !== 5'd2 || fp_retired_count !== 5'd6) begin n_err++; $display("FAIL prio_fp_wb: got %0d/%0d want 2/6", fp_wb_op.addr, fp_retired_count); end
    endtask

    task automatic test_speculation();
        @(negedge clk);
        current_jump_flag = 1'b0; exec_op = mk_op(5'd12, 32'h5555_AAAA, 1'b1, 1'b1); exec_valid = 1'b1; #1;
        n_cmp++; if (exec_ready !== 1'b1) begin n_err++; $display("FAIL spec_drop_ready: got %b want 1", exec_ready); end
        @(posedge clk); #1; exec_valid = 1'b0;
        n_cmp++; if (wb_valid !== 1'b0 || retired_count !== 5'd6) begin n_err++; $display("FAIL spec_drop: got %b/%0d want 0/6", wb_valid, retired_count); end
        n_cmp++; if (wb_op.addr !== 5'd1) begin n_err++; $display("FAIL spec_drop_hold: got %0d want 1", wb_op.addr); end
        @(negedge clk);
        current_jump_flag = 1'b1; exec_valid = 1'b1;
        @(posedge clk); #1; exec_valid = 1'b0;
        n_cmp++; if (wb_valid !== 1'b1 || wb_op !== mk_op(5'd12, 32'h5555_AAAA, 1'b0, 1'b1)) begin n_err++; $display("FAIL spec_commit: got %b/%h want 1/%h", wb_valid, wb_op, mk_op(5'd12, 32'h5555_AAAA, 1'b0, 1'b1)); end
        n_cmp++; if (retired_count !== 5'd7) begin n_err++; $display("FAIL spec_commit_retired: got %0d want 7", retired_count); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        exec_op = mk_op(5'd0, 32'h1234, 1'b0, 1'b1); exec_valid = 1'b1; #1;
        n_cmp++; if (exec_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b want 1", exec_ready); end
        @(posedge clk); #1; exec_valid = 1'b0;
        n_cmp++; if (wb_valid !== 1'b0 || forward.valid !== 1'b0 || retired_count !== 5'd7) begin n_err++; $display("FAIL x0_dropped: got %b/%b/%0d want 0/0/7", wb_valid, forward.valid, retired_count); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        exec_op = mk_op(5'd4, 32'h4444, 1'b0, 1'b1); exec_valid = 1'b1;
        @(posedge clk); #1; exec_valid = 1'b0;
        n_cmp++; if (wb_valid !== 1'b1 || retired_count !== 5'd8) begin n_err++; $display("FAIL mid_before: got %b/%0d want 1/8", wb_valid, retired_count); end
        #2; rst = 1'b1; #1;
        n_cmp++; if (wb_valid !== 1'b0 || retired_count !== 5'd0 || fp_wb_valid !== 1'b0) begin n_err++; $display("FAIL mid_async: got %b/%0d/%b want 0/0/0", wb_valid, retired_count, fp_wb_valid); end
        n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL mid_load_ready: got %b want 0", load_ready); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_saturate();
        @(negedge clk);
        exec_op = mk_op(5'd3, 32'h3333, 1'b0, 1'b1); exec_valid = 1'b1;
        repeat (40) @(posedge clk);
        #1; exec_valid = 1'b0;
        n_cmp++; if (retired_count !== 5'd31) begin n_err++; $display("FAIL saturate: got %0d want 31", retired_count); end
        n_cmp++; if (fp_retired_count !== 5'd8) begin n_err++; $display("FAIL wrap: got %0d want 8", fp_retired_count); end
    endtask

    initial begin
        test_reset();
        test_single_exec();
        test_load_format();
        test_arbitration();
        test_load_priority();
        test_speculation();
        test_x0();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
